cnn_layer_sequencer: RTL

- Parametrised successor to the fixed-sequence layer controller.
- Drives NUM_STAGES pipeline stages (conv, relu, maxpool, flatten, dense, ...) in index order using a start/done handshake per stage, not fixed one-cycle slots.
- Adds per-stage bypass, multi-image batch looping, a per-stage watchdog timeout, and abort.
- Sits at the top of the CNN datapath; stage index 0 is the first layer.

---
 rtl/cnn_layer_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for the CNN datapath: launches each non-bypassed stage in index order
// through a start/done handshake, loops over a batch of images, and guards each stage with a watchdog.
module cnn_layer_sequencer #(
    parameter int unsigned NUM_STAGES = 8,
    parameter int unsigned BATCH_W    = 8,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BATCH_W-1:0]    batch_count,
    input  logic [NUM_STAGES-1:0] stage_bypass,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  image_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_stage
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StNext,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      err_q, err_d;
    logic [BATCH_W-1:0]    images_q, images_d;
    logic [NUM_STAGES-1:0] bypass_q, bypass_d;
    logic [TIMEOUT_W-1:0]  limit_q, limit_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;

    // Returns {found, index} of the lowest non-bypassed stage at or above lo.
    function automatic logic [IDX_W:0] find_from(input logic [NUM_STAGES-1:0] byp, input int lo);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!byp[i] && i >= lo) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0] start_hit;
    logic [IDX_W:0] next_hit;
    logic [IDX_W:0] first_hit;

    always_comb begin
        start_hit = find_from(stage_bypass, 0);
        next_hit  = find_from(bypass_q, int'(idx_q) + 1);
        first_hit = find_from(bypass_q, 0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            err_q    <= '0;
            images_q <= '0;
            bypass_q <= '0;
            limit_q  <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            images_q <= images_d;
            bypass_q <= bypass_d;
            limit_q  <= limit_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        images_d = images_q;
        bypass_d = bypass_q;
        limit_d  = limit_q;
        wd_d     = wd_q;

        if (abort) begin
            state_d = StIdle;
            idx_d   = '0;
            err_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        bypass_d = stage_bypass;
                        limit_d  = timeout_limit;
                        images_d = (batch_count == '0) ? BATCH_W'(1) : batch_count;
                        if (start_hit[IDX_W]) begin
                            idx_d   = start_hit[IDX_W-1:0];
                            state_d = StLaunch;
                        end else begin
                            idx_d   = '0;
                            state_d = StDone;
                        end
                    end
                end
                StLaunch: begin
                    wd_d    = '0;
                    state_d = StWait;
                end
                StWait: begin
                    // Done on the expiry edge takes precedence over the timeout.
                    if (stage_done[idx_q]) begin
                        state_d = StNext;
                    end else if (limit_q != '0 && wd_q >= limit_q - TIMEOUT_W'(1)) begin
                        state_d = StError;
                        err_d   = idx_q;
                    end else if (wd_q != '1) begin
                        wd_d = wd_q + TIMEOUT_W'(1);
                    end
                end
                StNext: begin
                    if (next_hit[IDX_W]) begin
                        idx_d   = next_hit[IDX_W-1:0];
                        state_d = StLaunch;
                    end else begin
                        images_d = images_q - BATCH_W'(1);
                        if (images_q == BATCH_W'(1)) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = first_hit[IDX_W-1:0];
                            state_d = StLaunch;
                        end
                    end
                end
                StError: begin
                    state_d = StError;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    logic [NUM_STAGES-1:0] idx_onehot;

    always_comb begin
        idx_onehot   = NUM_STAGES'(1) << idx_q;
        stage_start  = (state_q == StLaunch) ? idx_onehot : '0;
        stage_active = (state_q == StLaunch || state_q == StWait) ? idx_onehot : '0;
        stage_idx    = idx_q;
        image_done   = (state_q == StNext) && !next_hit[IDX_W];
        busy         = (state_q == StLaunch) || (state_q == StWait) || (state_q == StNext);
        done         = (state_q == StDone);
        error        = (state_q == StError);
        err_stage    = (state_q == StError) ? err_q : '0;
    end

endmodule
